alu_operand_loader: RTL and testbench

- Upstream stage of the modular ALU datapath (and, or, add, ... units).
- Captures operand A, operand B and the opcode from board switches, one field per button press.
- Button inputs are synchronised and debounced.
- Presents registered, stable operands and opcode to the ALU, with a valid flag once all three fields are loaded.

---
 rtl/alu_operand_loader_pkg.sv | 28 ++
 rtl/alu_operand_loader_btn_debounce.sv | 75 +++++++
 rtl/alu_operand_loader.sv | 148 ++++++++++++++
 tb/tb_alu_operand_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_loader_pkg.sv
// ============================================================================
// Module      : alu_operand_loader_pkg
// Description : Shared definitions for the ALU operand loader: loader FSM
//               state encodings and the default button debounce length.
//               Operand and opcode widths stay as parameters on the modules
//               that use them, matching the other datapath units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_operand_loader_pkg;

    // Loader FSM states. The encoding is visible on o_state and drives LEDs,
    // so the values are fixed.
    typedef enum logic [1:0] {
        ST_WAIT_A  = 2'd0,
        ST_WAIT_B  = 2'd1,
        ST_WAIT_OP = 2'd2,
        ST_READY   = 2'd3
    } state_t;

    // Default number of consecutive stable cycles needed to accept a
    // button level change.
    localparam int c_deb_cycles_default = 4;

endpackage : alu_operand_loader_pkg

`default_nettype wire

// File: rtl/alu_operand_loader_btn_debounce.sv
// ============================================================================
// Module      : btn_debounce
// Description : Synchroniser plus debouncer for one raw mechanical button.
//               The raw input passes through a 2-FF synchroniser. A counter
//               runs while the synchronised level differs from the
//               debounced level and clears whenever they agree. Once it has
//               reached DEB_CYCLES and the difference persists, the
//               debounced level toggles. A one-cycle pulse marks each
//               debounced 0->1 transition.
// Ports       : i_clk    - system clock
//               i_rst_n  - asynchronous active-low reset
//               i_btn    - raw, asynchronous, bouncy button input
//               o_level  - debounced button level
//               o_rise   - one-cycle pulse on debounced press
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce
    import alu_operand_loader_pkg::*;
#(
    parameter int DEB_CYCLES = c_deb_cycles_default
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_btn,
    output logic o_level,
    output logic o_rise
);

    localparam int                 c_cnt_w   = $clog2(DEB_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEB_CYCLES);

    // Parameter sanity check at elaboration time.
    if (DEB_CYCLES < 2) begin : g_bad_deb_cycles
        $error("btn_debounce: DEB_CYCLES must be >= 2");
    end

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_rise;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                // Difference has persisted long enough: accept the new
                // level. Only a 0->1 acceptance raises the pulse.
                r_level <= ~r_level;
                r_rise  <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/alu_operand_loader.sv
// ============================================================================
// Module      : alu_operand_loader
// Description : Upstream stage of the ALU datapath. Captures operand A,
//               operand B and the opcode from the switch bank, one field per
//               debounced button press, in the fixed order A -> B -> OP.
//               Presents registered operands and opcode plus a valid flag
//               once all three fields are loaded. Pressing A from READY
//               starts a new transaction; B and OP keep their old values
//               until they are reloaded.
// Ports       : i_clk    - system clock
//               i_rst_n  - asynchronous active-low reset
//               i_sw     - switch bank, sampled on each load
//               i_btn_a  - raw button, load operand A
//               i_btn_b  - raw button, load operand B
//               i_btn_op - raw button, load opcode
//               o_a      - registered operand A
//               o_b      - registered operand B
//               o_op     - registered opcode (low OPW switch bits)
//               o_valid  - all three fields loaded (state READY)
//               o_state  - current FSM state, for LEDs
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_operand_loader
    import alu_operand_loader_pkg::*;
#(
    parameter int N          = 8,
    parameter int OPW        = 6,
    parameter int DEB_CYCLES = c_deb_cycles_default
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_sw,
    input  logic           i_btn_a,
    input  logic           i_btn_b,
    input  logic           i_btn_op,
    output logic [N-1:0]   o_a,
    output logic [N-1:0]   o_b,
    output logic [OPW-1:0] o_op,
    output logic           o_valid,
    output logic [1:0]     o_state
);

    // The opcode is taken from the low switch bits.
    if (OPW > N) begin : g_bad_opw
        $error("alu_operand_loader: OPW must be <= N");
    end

    // ------------------------------------------------------------------
    // Button conditioning: index 0 = A, 1 = B, 2 = OP.
    // ------------------------------------------------------------------
    logic [2:0] w_btn_raw;
    logic [2:0] w_pulse;
    logic [2:0] w_level_unused;   // debounced levels are not needed here

    assign w_btn_raw = {i_btn_op, i_btn_b, i_btn_a};

    for (genvar gi = 0; gi < 3; gi++) begin : g_debounce
        btn_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_btn_debounce (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_btn   (w_btn_raw[gi]),
            .o_level (w_level_unused[gi]),
            .o_rise  (w_pulse[gi])
        );
    end

    // ------------------------------------------------------------------
    // Loader FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_load_a;
    logic           w_load_b;
    logic           w_load_op;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [OPW-1:0] r_op;
    logic           r_valid;

    // Only the pulse expected in the current state is looked at; any other
    // pulse in the same cycle is dropped, not remembered.
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_op   = 1'b0;
        case (r_state)
            ST_WAIT_A, ST_READY: begin
                if (w_pulse[0]) begin
                    w_load_a    = 1'b1;
                    w_state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (w_pulse[1]) begin
                    w_load_b    = 1'b1;
                    w_state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (w_pulse[2]) begin
                    w_load_op   = 1'b1;
                    w_state_nxt = ST_READY;
                end
            end
            default: begin
                w_state_nxt = ST_WAIT_A;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_a) begin
                r_a <= i_sw;
            end
            if (w_load_b) begin
                r_b <= i_sw;
            end
            if (w_load_op) begin
                r_op <= i_sw[OPW-1:0];
            end
            // Registered from the next state so valid tracks r_state exactly,
            // falling in the same cycle A reloads from READY.
            r_valid <= (w_state_nxt == ST_READY);
        end
    end

    assign o_a     = r_a;
    assign o_b     = r_b;
    assign o_op    = r_op;
    assign o_valid = r_valid;
    assign o_state = r_state;

endmodule : alu_operand_loader

`default_nettype wire

// File: tb/tb_alu_operand_loader.sv
// ============================================================================
// Module      : tb_alu_operand_loader
// Description : Self-checking bench for alu_operand_loader. A vector table
//               of button/switch presses with expected register contents
//               drives a scoreboard queue; hand-written sequences cover
//               bounce rejection, long holds, async reset and a button held
//               through reset release.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_operand_loader;

    localparam int N   = 8;
    localparam int OPW = 6;
    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   sw;
    logic           btn_a;
    logic           btn_b;
    logic           btn_op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [OPW-1:0] op;
    logic           valid;
    logic [1:0]     state;

    always #5 clk = ~clk;

    alu_operand_loader #(
        .N          (N),
        .OPW        (OPW),
        .DEB_CYCLES (DEB)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_sw     (sw),
        .i_btn_a  (btn_a),
        .i_btn_b  (btn_b),
        .i_btn_op (btn_op),
        .o_a      (a),
        .o_b      (b),
        .o_op     (op),
        .o_valid  (valid),
        .o_state  (state)
    );

    typedef struct {
        logic [N-1:0]   a;
        logic [N-1:0]   b;
        logic [OPW-1:0] op;
        logic           valid;
        logic [1:0]     st;
    } exp_t;

    typedef struct {
        logic [2:0]   btn;   // bit0 = A, bit1 = B, bit2 = OP
        logic [N-1:0] sw;
        exp_t         exp;
    } vec_t;

    exp_t sbq[$];
    vec_t vecs[10];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, "_a"},     32'(a),     32'(e.a));
        chk({tag, "_b"},     32'(b),     32'(e.b));
        chk({tag, "_op"},    32'(op),    32'(e.op));
        chk({tag, "_valid"}, 32'(valid), 32'(e.valid));
        chk({tag, "_state"}, 32'(state), 32'(e.st));
    endtask

    // Press buttons m with switches s. The first sampling edge is k; the
    // outputs must still show prev at k+LAT-1 and the popped expectation at
    // k+LAT. After release the switches are scrambled and the registers
    // must hold.
    task automatic press_check(input string tag, input logic [2:0] m,
                               input logic [N-1:0] s, input exp_t prev);
        exp_t e;
        @(negedge clk);
        sw = s;
        {btn_op, btn_b, btn_a} = m;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk({tag, "_early_state"}, 32'(state), 32'(prev.st));
        chk({tag, "_early_a"},     32'(a),     32'(prev.a));
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
        end else begin
            e = sbq.pop_front();
            check_all(tag, e);
            @(negedge clk);
            {btn_op, btn_b, btn_a} = 3'b000;
            sw = 8'($urandom);
            repeat (12) @(negedge clk);
            check_all({tag, "_hold"}, e);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t cur;
        exp_t zero;
        int   lat;
        int   bounce_changes;
        int   extra_changes;

        zero = '{a: 8'h00, b: 8'h00, op: 6'h00, valid: 1'b0, st: 2'd0};

        vecs[0] = '{btn: 3'b010, sw: 8'hFF, exp: '{8'h00, 8'h00, 6'h00, 1'b0, 2'd0}};
        vecs[1] = '{btn: 3'b100, sw: 8'hFF, exp: '{8'h00, 8'h00, 6'h00, 1'b0, 2'd0}};
        vecs[2] = '{btn: 3'b001, sw: 8'h3C, exp: '{8'h3C, 8'h00, 6'h00, 1'b0, 2'd1}};
        vecs[3] = '{btn: 3'b001, sw: 8'h99, exp: '{8'h3C, 8'h00, 6'h00, 1'b0, 2'd1}};
        vecs[4] = '{btn: 3'b010, sw: 8'h5A, exp: '{8'h3C, 8'h5A, 6'h00, 1'b0, 2'd2}};
        vecs[5] = '{btn: 3'b100, sw: 8'h24, exp: '{8'h3C, 8'h5A, 6'h24, 1'b1, 2'd3}};
        vecs[6] = '{btn: 3'b010, sw: 8'h01, exp: '{8'h3C, 8'h5A, 6'h24, 1'b1, 2'd3}};
        vecs[7] = '{btn: 3'b001, sw: 8'h77, exp: '{8'h77, 8'h5A, 6'h24, 1'b0, 2'd1}};
        vecs[8] = '{btn: 3'b011, sw: 8'h11, exp: '{8'h77, 8'h11, 6'h24, 1'b0, 2'd2}};
        vecs[9] = '{btn: 3'b110, sw: 8'hEA, exp: '{8'h77, 8'h11, 6'h2A, 1'b1, 2'd3}};

        // ---------------- reset state ----------------
        rst_n  = 1'b0;
        sw     = '0;
        btn_a  = 1'b0;
        btn_b  = 1'b0;
        btn_op = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", zero);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_all("idle", zero);

        // ---------------- vector table ----------------
        cur = zero;
        for (int i = 0; i < 10; i++) begin
            sbq.push_back(vecs[i].exp);
            press_check($sformatf("v%0d", i), vecs[i].btn, vecs[i].sw, cur);
            cur = vecs[i].exp;
        end

        // ---------------- bounce on A from READY ----------------
        @(negedge clk);
        sw = 8'h42;
        bounce_changes = 0;
        for (int i = 0; i < 5; i++) begin
            btn_a = 1'b1;
            repeat (2) begin
                @(negedge clk);
                if (state != 2'd3 || a != 8'h77) bounce_changes++;
            end
            btn_a = 1'b0;
            repeat (2) begin
                @(negedge clk);
                if (state != 2'd3 || a != 8'h77) bounce_changes++;
            end
        end
        chk("bounce_no_load", 32'(bounce_changes), 32'd0);
        btn_a = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && state == 2'd1) lat = i;
        end
        chk("bounce_latency", 32'(lat), 32'(LAT));
        // Held for a further 100 cycles with the switches changing.
        extra_changes = 0;
        sw = 8'hA5;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (state != 2'd1 || a != 8'h42) extra_changes++;
        end
        chk("hold_single_load", 32'(extra_changes), 32'd0);
        cur = '{a: 8'h42, b: 8'h11, op: 6'h2A, valid: 1'b0, st: 2'd1};
        check_all("restart", cur);
        btn_a = 1'b0;
        repeat (12) @(negedge clk);

        // ---------------- back to READY, then async reset ----------------
        sbq.push_back('{a: 8'h42, b: 8'h60, op: 6'h2A, valid: 1'b0, st: 2'd2});
        press_check("rb", 3'b010, 8'h60, cur);
        cur = '{a: 8'h42, b: 8'h60, op: 6'h2A, valid: 1'b0, st: 2'd2};
        sbq.push_back('{a: 8'h42, b: 8'h60, op: 6'h3F, valid: 1'b1, st: 2'd3});
        press_check("rop", 3'b100, 8'h3F, cur);

        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async_reset", zero);

        // ---------------- button held through reset release ----------------
        btn_a = 1'b1;
        sw    = 8'h5C;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        repeat (LAT - 1) @(posedge clk);
        #1;
        chk("held_rst_early_state", 32'(state), 32'd0);
        @(posedge clk);
        #1;
        chk("held_rst_state", 32'(state), 32'd1);
        chk("held_rst_a",     32'(a),     32'h5C);
        btn_a = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_operand_loader

`default_nettype wire
